// File: rtl/target_slew_arbiter.sv
// Fixed-priority arbiter over N_SRC coordinate sources that slew-limits the arm
// (x,y) target toward the winner and holds the servo enable after each move.
module target_slew_arbiter #(
    parameter int N_SRC       = 4,
    parameter int W           = 8,
    parameter int STEP_DIV    = 10_000,
    parameter int MAX_STEP    = 1,
    parameter int HOLD_CYCLES = 140_000_000,
    parameter int DEFAULT_X   = 2,
    parameter int DEFAULT_Y   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         src_valid,
    input  logic [N_SRC*W-1:0]       src_x,
    input  logic [N_SRC*W-1:0]       src_y,
    input  logic                     force_default,
    output logic [W-1:0]             tgt_x,
    output logic [W-1:0]             tgt_y,
    output logic [$clog2(N_SRC)-1:0] sel_src,
    output logic                     sel_valid,
    output logic                     servo_en,
    output logic                     settled
);

    localparam int SW = $clog2(N_SRC);
    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [W:0]    STEP      = (W + 1)'(MAX_STEP);
    localparam logic [W-1:0]  DEF_X     = W'(DEFAULT_X);
    localparam logic [W-1:0]  DEF_Y     = W'(DEFAULT_Y);

    typedef enum logic {ST_SETTLED = 1'b0, ST_SLEWING = 1'b1} state_t;

    state_t          state, state_d;
    logic [W-1:0]    goal_x, goal_y;
    logic [W-1:0]    win_x, win_y;
    logic [SW-1:0]   win_idx;
    logic            win_valid;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [W-1:0]    tgt_x_d, tgt_y_d;
    logic [HW-1:0]   hold, hold_d;

    // One axis step toward the goal, computed with a spare bit so it cannot wrap.
    function automatic logic [W-1:0] slew_axis(input logic [W-1:0] cur, input logic [W-1:0] gl);
        logic [W:0] c, g, s;
        c = {1'b0, cur};
        g = {1'b0, gl};
        if (g >= c) begin
            s = ((g - c) <= STEP) ? g : (c + STEP);
        end else begin
            s = ((c - g) <= STEP) ? g : (c - STEP);
        end
        return s[W-1:0];
    endfunction

    // src_valid is a level request with no ready: the lowest asserted index wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_x     = DEF_X;
        win_y     = DEF_Y;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                win_valid = 1'b1;
                win_idx   = SW'(i);
                win_x     = src_x[i*W +: W];
                win_y     = src_y[i*W +: W];
            end
        end
        if (force_default) begin
            win_valid = 1'b0;
            win_idx   = '0;
            win_x     = DEF_X;
            win_y     = DEF_Y;
        end
    end

    assign tick    = (tick_cnt == TICK_LAST);
    assign tgt_x_d = tick ? slew_axis(tgt_x, goal_x) : tgt_x;
    assign tgt_y_d = tick ? slew_axis(tgt_y, goal_y) : tgt_y;

    always_comb begin
        hold_d = hold;
        if ((tgt_x_d != tgt_x) || (tgt_y_d != tgt_y)) begin
            hold_d = HOLD_LOAD;
        end else if (hold != '0) begin
            hold_d = hold - 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_SETTLED: if ((goal_x != tgt_x) || (goal_y != tgt_y)) state_d = ST_SLEWING;
            ST_SLEWING: if ((goal_x == tgt_x) && (goal_y == tgt_y)) state_d = ST_SETTLED;
            default:    state_d = ST_SETTLED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SETTLED;
            goal_x    <= DEF_X;
            goal_y    <= DEF_Y;
            tgt_x     <= DEF_X;
            tgt_y     <= DEF_Y;
            sel_src   <= '0;
            sel_valid <= 1'b0;
            tick_cnt  <= '0;
            hold      <= '0;
            servo_en  <= 1'b0;
        end else begin
            state     <= state_d;
            goal_x    <= win_x;
            goal_y    <= win_y;
            tgt_x     <= tgt_x_d;
            tgt_y     <= tgt_y_d;
            sel_src   <= win_idx;
            sel_valid <= win_valid;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            hold      <= hold_d;
            servo_en  <= (hold_d != '0);
        end
    end

    assign settled = (state == ST_SETTLED);

endmodule

// File: tb/tb_target_slew_arbiter.sv
// Directed bench: instance a (STEP_DIV=4, MAX_STEP=1, HOLD=10) for priority, slew,
// hold, fallback and reset; instance b (STEP_DIV=1, MAX_STEP=3) for edge clamping.
module tb_target_slew_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_force;
    logic [3:0]  a_valid;
    logic [31:0] a_x, a_y;
    logic [7:0]  a_tgt_x, a_tgt_y;
    logic [1:0]  a_sel;
    logic        a_sel_valid, a_servo, a_settled;

    logic        b_reset, b_force;
    logic [3:0]  b_valid;
    logic [31:0] b_x, b_y;
    logic [7:0]  b_tgt_x, b_tgt_y;
    logic [1:0]  b_sel;
    logic        b_sel_valid, b_servo, b_settled;

    target_slew_arbiter #(.N_SRC(4), .W(8), .STEP_DIV(4), .MAX_STEP(1), .HOLD_CYCLES(10),
                          .DEFAULT_X(2), .DEFAULT_Y(2)) dut_a (
        .clk(clk), .reset(a_reset), .src_valid(a_valid), .src_x(a_x), .src_y(a_y),
        .force_default(a_force), .tgt_x(a_tgt_x), .tgt_y(a_tgt_y), .sel_src(a_sel),
        .sel_valid(a_sel_valid), .servo_en(a_servo), .settled(a_settled)
    );

    target_slew_arbiter #(.N_SRC(4), .W(8), .STEP_DIV(1), .MAX_STEP(3), .HOLD_CYCLES(10),
                          .DEFAULT_X(2), .DEFAULT_Y(2)) dut_b (
        .clk(clk), .reset(b_reset), .src_valid(b_valid), .src_x(b_x), .src_y(b_y),
        .force_default(b_force), .tgt_x(b_tgt_x), .tgt_y(b_tgt_y), .sel_src(b_sel),
        .sel_valid(b_sel_valid), .servo_en(b_servo), .settled(b_settled)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_a_settled(input string tag, input int max);
        int i;
        i = 0;
        while (!a_settled && i < max) begin
            step(1);
            i++;
        end
        check({tag, "_settle_timeout"}, a_settled, 1);
    endtask

    task automatic wait_b_settled(input string tag, input int max);
        int i;
        i = 0;
        while (!b_settled && i < max) begin
            step(1);
            i++;
        end
        check({tag, "_settle_timeout"}, b_settled, 1);
    endtask

    initial begin
        int bad, last_chg, cyc, guard;
        logic [7:0] px, py, e;

        a_reset = 1'b1; a_force = 1'b0; a_valid = '0; a_x = '0; a_y = '0;
        b_reset = 1'b1; b_force = 1'b0; b_valid = '0; b_x = '0; b_y = '0;
        step(3);

        check("rst_tgt_x", a_tgt_x, 2);
        check("rst_tgt_y", a_tgt_y, 2);
        check("rst_sel_src", a_sel, 0);
        check("rst_sel_valid", a_sel_valid, 0);
        check("rst_servo", a_servo, 0);
        check("rst_settled", a_settled, 1);

        // Slew from reset toward (5,2): one x step every 4 cycles, hold 10 after last.
        for (int k = 1; k <= 22; k++) exp_q.push_back((k < 4) ? 8'd2 : (k < 8) ? 8'd3 : (k < 12) ? 8'd4 : 8'd5);
        a_reset = 1'b0;
        a_valid = 4'b0001; a_x[7:0] = 8'd5; a_y[7:0] = 8'd2;
        for (int k = 1; k <= 22; k++) begin
            step(1);
            e = exp_q.pop_front();
            check($sformatf("slew_x_k%0d", k), a_tgt_x, e);
            check($sformatf("slew_y_k%0d", k), a_tgt_y, 2);
            check($sformatf("slew_settled_k%0d", k), a_settled, (k == 1 || k >= 13) ? 1 : 0);
            check($sformatf("slew_servo_k%0d", k), a_servo, (k >= 4 && k <= 21) ? 1 : 0);
            if (k == 1) begin
                check("slew_sel_src", a_sel, 0);
                check("slew_sel_valid", a_sel_valid, 1);
            end
        end

        // Priority: sources 1 and 2 valid, source 1 wins.
        a_valid = 4'b0110;
        a_x[15:8] = 8'd10; a_y[15:8] = 8'd20;
        a_x[23:16] = 8'd30; a_y[23:16] = 8'd40;
        step(1);
        check("prio_sel_src", a_sel, 1);
        check("prio_sel_valid", a_sel_valid, 1);
        step(1);
        wait_a_settled("prio", 300);
        check("prio_goal_x", a_tgt_x, 10);
        check("prio_goal_y", a_tgt_y, 20);
        a_valid = 4'b0100;
        step(1);
        check("drop_sel_src", a_sel, 2);
        check("drop_sel_valid", a_sel_valid, 1);
        step(20);

        // Fallback via force_default mid-slew: back to (2,2), at most one step per tick.
        a_force = 1'b1;
        step(1);
        check("force_sel_valid", a_sel_valid, 0);
        check("force_sel_src", a_sel, 0);
        bad = 0; last_chg = -100; cyc = 0; guard = 0;
        px = a_tgt_x; py = a_tgt_y;
        while (!a_settled && guard < 400) begin
            step(1);
            cyc++; guard++;
            if ((int'(a_tgt_x) - int'(px) > 1) || (int'(px) - int'(a_tgt_x) > 1) ||
                (int'(a_tgt_y) - int'(py) > 1) || (int'(py) - int'(a_tgt_y) > 1)) bad++;
            if ((a_tgt_x != px) || (a_tgt_y != py)) begin
                if (cyc - last_chg < 4) bad++;
                last_chg = cyc;
            end
            px = a_tgt_x; py = a_tgt_y;
        end
        check("force_settle_timeout", a_settled, 1);
        check("force_rate_violations", bad, 0);
        check("force_tgt_x", a_tgt_x, 2);
        check("force_tgt_y", a_tgt_y, 2);

        // Fallback via the valid source dropping away.
        a_force = 1'b0;
        step(14);
        check("redrive_moved", (a_tgt_x != 8'd2) ? 1 : 0, 1);
        a_valid = 4'b0000;
        step(1);
        check("none_sel_valid", a_sel_valid, 0);
        check("none_sel_src", a_sel, 0);
        step(1);
        wait_a_settled("none", 400);
        check("none_tgt_x", a_tgt_x, 2);
        check("none_tgt_y", a_tgt_y, 2);

        // Reset while slewing through (40,40).
        a_valid = 4'b0001; a_x[7:0] = 8'd60; a_y[7:0] = 8'd60;
        guard = 0;
        while (a_tgt_x != 8'd40 && guard < 400) begin
            step(1);
            guard++;
        end
        check("mid_reach_x", a_tgt_x, 40);
        check("mid_reach_y", a_tgt_y, 40);
        a_reset = 1'b1;
        step(1);
        check("midrst_tgt_x", a_tgt_x, 2);
        check("midrst_tgt_y", a_tgt_y, 2);
        check("midrst_servo", a_servo, 0);
        check("midrst_settled", a_settled, 1);
        check("midrst_sel_valid", a_sel_valid, 0);
        a_valid = 4'b0000;
        step(2);
        a_reset = 1'b0;
        step(30);
        check("idle_servo", a_servo, 0);
        check("idle_tgt_x", a_tgt_x, 2);
        check("idle_settled", a_settled, 1);

        // Clamp at the top and bottom of the range with MAX_STEP=3, tick every cycle.
        b_reset = 1'b0;
        b_valid = 4'b0001; b_x[7:0] = 8'd254; b_y[7:0] = 8'd1;
        step(2);
        wait_b_settled("b_first", 200);
        check("b_at_x", b_tgt_x, 254);
        check("b_at_y", b_tgt_y, 1);
        b_x[7:0] = 8'd255; b_y[7:0] = 8'd0;
        step(1);
        check("b_oldgoal_x", b_tgt_x, 254);
        check("b_oldgoal_y", b_tgt_y, 1);
        step(1);
        check("b_clamp_x", b_tgt_x, 255);
        check("b_clamp_y", b_tgt_y, 0);
        b_x[7:0] = 8'd0; b_y[7:0] = 8'd255;
        step(2);
        check("b_step_x", b_tgt_x, 252);
        check("b_step_y", b_tgt_y, 3);
        wait_b_settled("b_far", 200);
        check("b_far_x", b_tgt_x, 0);
        check("b_far_y", b_tgt_y, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
